// File: rtl/mem_access_stage.sv
// MEM-stage access controller: byte/half/word loads and stores on a word-wide DataMemory.
// Sub-word stores use a 2-cycle read-modify-write (IDLE -> RMW_WR) and hold off upstream.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake from EX/MEM
//   is_load, is_store, size,
//   ld_unsigned, addr,
//   store_data, rd_in           request fields
//   dm_MemRead, dm_MemWrite,
//   dm_address, dm_writeData,
//   dm_readData                 DataMemory interface (read is combinational)
//   wb_valid, wb_data, wb_rd    registered load result toward MEM/WB
//   misaligned                  pulse one cycle after a misaligned request
module mem_access_stage #(
    parameter int ADDR_W     = 32,
    parameter int RD_W       = 5,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [RD_W-1:0]   rd_in,
    output logic              dm_MemRead,
    output logic              dm_MemWrite,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_writeData,
    input  logic [31:0]       dm_readData,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              misaligned
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rmw_addr;
    logic [31:0]       rmw_data;

    logic              accept;
    logic              one_op;
    logic              mis;
    logic              do_load;
    logic              do_wstore;
    logic              do_sstore;
    logic [4:0]        sh;
    logic [31:0]       mask;
    logic [31:0]       lane;
    logic [31:0]       merged;
    logic [31:0]       shifted;
    logic [31:0]       ld_val;
    logic [ADDR_W-1:0] word_addr;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign one_op    = is_load ^ is_store;
    assign word_addr = {addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        mis = 1'b0;
        unique case (size)
            2'b00: mis = 1'b0;
            2'b01: mis = addr[0];
            2'b10: mis = |addr[1:0];
            2'b11: mis = 1'b1;
        endcase
    end

    // Requests with both or neither of is_load/is_store are silent no-ops.
    assign do_load   = accept & one_op & is_load & ~mis;
    assign do_wstore = accept & one_op & is_store & ~mis & (size == 2'b10);
    assign do_sstore = accept & one_op & is_store & ~mis & (size != 2'b10);

    // Bit offset of the addressed lane inside the memory word.
    always_comb begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        lane = store_data;
        unique case (size)
            2'b00: begin
                sh   = BIG_ENDIAN ? {~addr[1:0], 3'b000}
                                  : { addr[1:0], 3'b000};
                mask = 32'h0000_00FF << sh;
                lane = {24'b0, store_data[7:0]} << sh;
            end
            2'b01: begin
                sh   = BIG_ENDIAN ? {~addr[1], 4'b0000}
                                  : { addr[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
                lane = {16'b0, store_data[15:0]} << sh;
            end
            default: begin
                sh   = 5'd0;
                mask = 32'hFFFF_FFFF;
                lane = store_data;
            end
        endcase
    end

    assign merged  = (dm_readData & ~mask) | lane;
    assign shifted = dm_readData >> sh;

    always_comb begin
        ld_val = shifted;
        unique case (size)
            2'b00: ld_val = {{24{~ld_unsigned & shifted[7]}},
                             shifted[7:0]};
            2'b01: ld_val = {{16{~ld_unsigned & shifted[15]}},
                             shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    // Strobes are forced low during reset so an in-flight RMW write is dropped.
    assign dm_MemRead  = ~reset & (do_load | do_sstore);
    assign dm_MemWrite = ~reset & ((state == RMW_WR) | do_wstore);
    assign dm_address  = (state == RMW_WR) ? rmw_addr : word_addr;
    assign dm_writeData = (state == RMW_WR) ? rmw_data : store_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            wb_data    <= 32'b0;
            wb_rd      <= '0;
            rmw_addr   <= '0;
            rmw_data   <= 32'b0;
        end else begin
            wb_valid   <= do_load;
            misaligned <= accept & one_op & mis;
            if (do_load) begin
                wb_data <= ld_val;
                wb_rd   <= rd_in;
            end
            unique case (state)
                IDLE: begin
                    if (do_sstore) begin
                        state    <= RMW_WR;
                        rmw_addr <= word_addr;
                        rmw_data <= merged;
                    end
                end
                RMW_WR: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset/top-word sequences,
// and random traffic checked against a byte-array memory model.
module tb_mem_access_stage;

    localparam bit BE = 1'b1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [31:0] dm_address;
    logic [31:0] dm_writeData;
    logic [31:0] dm_readData;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misaligned;

    mem_access_stage #(
        .ADDR_W(32), .RD_W(5), .BIG_ENDIAN(BE)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store),
        .size(size), .ld_unsigned(ld_unsigned),
        .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
        .dm_address(dm_address), .dm_writeData(dm_writeData),
        .dm_readData(dm_readData),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory: 64 words, address bits above [7:2] alias.
    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    assign dm_readData = mem[dm_address[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (dm_MemWrite) mem[dm_address[7:2]] <= dm_writeData;
    end

    // Reference model: byte-addressed memory.
    logic [7:0] mb [256];

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
    } req_t;

    typedef struct {
        req_t        r;
        int          waits;
        logic        mr;
        logic        v;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic ld, input logic st,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] rd);
        req_t r;
        r.ld = ld; r.st = st; r.size = sz; r.uns = uns;
        r.addr = a; r.sd = d; r.rd = rd;
        return r;
    endfunction

    function automatic int nbytes(input req_t r);
        return 1 << r.size;
    endfunction

    function automatic logic mdl_mis(input req_t r);
        if (r.size == 2'b11) return 1'b1;
        return (int'(r.addr[1:0]) % nbytes(r)) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(input req_t r);
        int n = nbytes(r);
        int a = int'(r.addr[7:0]);
        logic [31:0] v = 32'b0;
        for (int i = 0; i < n; i++) begin
            if (BE) v = (v << 8) | {24'b0, mb[a + i]};
            else v = v | ({24'b0, mb[a + i]} << (8 * i));
        end
        if (!r.uns && n < 4 && v[8 * n - 1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic mdl_store(input req_t r);
        int n = nbytes(r);
        int a = int'(r.addr[7:0]);
        for (int i = 0; i < n; i++) begin
            if (BE) mb[a + i] = r.sd[8 * (n - 1 - i) +: 8];
            else mb[a + i] = r.sd[8 * i +: 8];
        end
    endtask

    function automatic logic [31:0] mdl_word(input int w);
        logic [31:0] v = 32'b0;
        for (int k = 0; k < 4; k++) begin
            if (BE) v = (v << 8) | {24'b0, mb[4 * w + k]};
            else v = v | ({24'b0, mb[4 * w + k]} << (8 * k));
        end
        return v;
    endfunction

    task automatic preset(input int idx, input logic [31:0] v);
        pre_we = 1'b1;
        pre_idx = idx[5:0];
        pre_val = v;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (BE) mb[4 * idx + k] = v[31 - 8 * k -: 8];
            else mb[4 * idx + k] = v[8 * k +: 8];
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request at a negedge; retry while not ready.
    // Returns at the negedge after acceptance with accept-cycle strobes.
    task automatic issue(input req_t r, output int waits,
                         output logic mr, output logic mw,
                         output logic [31:0] ad);
        logic rdy;
        waits = 0;
        mr = 1'b0;
        mw = 1'b0;
        ad = 32'b0;
        req_valid = 1'b1;
        is_load = r.ld;
        is_store = r.st;
        size = r.size;
        ld_unsigned = r.uns;
        addr = r.addr;
        store_data = r.sd;
        rd_in = r.rd;
        for (int t = 0; t < 5; t++) begin
            #1;
            rdy = req_ready;
            mr = dm_MemRead;
            mw = dm_MemWrite;
            ad = dm_address;
            @(posedge clk);
            @(negedge clk);
            if (rdy) return;
            waits++;
        end
        tests++;
        fails++;
        $display("FAIL issue_timeout: got not-ready expected ready");
    endtask

    vec_t tbl [$];

    task automatic add(input req_t r, input int w, input logic mr,
                       input logic v, input logic [31:0] d,
                       input logic m);
        vec_t e;
        e.r = r; e.waits = w; e.mr = mr; e.v = v; e.data = d; e.mis = m;
        tbl.push_back(e);
    endtask

    initial begin
        int          w;
        logic        mr;
        logic        mw;
        logic [31:0] ad;
        logic        pend;
        req_t        r;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        is_load = 1'b0;
        is_store = 1'b0;
        size = 2'b00;
        ld_unsigned = 1'b0;
        addr = 32'b0;
        store_data = 32'b0;
        rd_in = 5'd0;
        pre_we = 1'b0;
        pre_idx = 6'd0;
        pre_val = 32'b0;
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;

        // Reset state; strobes stay low while reset even with a request.
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        is_load = 1'b1;
        size = 2'b10;
        #1;
        chk("rst_no_read", {31'b0, dm_MemRead}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        is_load = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_mis", {31'b0, misaligned}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            case (i)
                0: preset(i, 32'hA000_0000);
                1: preset(i, 32'hB000_0001);
                2: preset(i, 32'hC000_0002);
                3: preset(i, 32'hD000_0003);
                4: preset(i, 32'h8899_AABB);
                default: preset(i, $urandom);
            endcase
        end

        // ld st sz uns addr data rd | waits mr v data mis
        add(mk(1, 0, 0, 0, 32'h11, 0, 1), 0, 1, 1, 32'hFFFF_FF99, 0);
        add(mk(1, 0, 0, 1, 32'h11, 0, 2), 0, 1, 1, 32'h0000_0099, 0);
        add(mk(1, 0, 1, 0, 32'h12, 0, 3), 0, 1, 1, 32'hFFFF_AABB, 0);
        add(mk(1, 0, 1, 0, 32'h13, 0, 4), 0, 0, 0, 32'h0, 1);
        add(mk(0, 1, 0, 0, 32'h12, 32'h55, 5), 0, 1, 0, 32'h0, 0);
        add(mk(1, 0, 2, 0, 32'h10, 0, 6), 1, 1, 1, 32'h8899_55BB, 0);
        add(mk(0, 1, 2, 0, 32'h10, 32'h8899_AABB, 7), 0, 0, 0, 0, 0);
        add(mk(0, 1, 1, 0, 32'h10, 32'h1234, 8), 0, 1, 0, 0, 0);
        add(mk(0, 1, 2, 0, 32'h14, 32'hDEAD_BEEF, 9), 1, 0, 0, 0, 0);
        add(mk(1, 0, 2, 0, 32'h10, 0, 10), 0, 1, 1, 32'h1234_AABB, 0);
        add(mk(1, 0, 2, 0, 32'h14, 0, 11), 0, 1, 1, 32'hDEAD_BEEF, 0);
        add(mk(1, 0, 2, 0, 32'h00, 0, 12), 0, 1, 1, 32'hA000_0000, 0);
        add(mk(1, 0, 2, 0, 32'h04, 0, 13), 0, 1, 1, 32'hB000_0001, 0);
        add(mk(1, 0, 2, 0, 32'h08, 0, 14), 0, 1, 1, 32'hC000_0002, 0);
        add(mk(1, 0, 2, 0, 32'h0C, 0, 15), 0, 1, 1, 32'hD000_0003, 0);
        add(mk(1, 1, 2, 0, 32'h10, 0, 16), 0, 0, 0, 32'h0, 0);
        add(mk(1, 0, 3, 0, 32'h10, 0, 17), 0, 0, 0, 32'h0, 1);
        add(mk(0, 1, 2, 0, 32'h16, 32'h1, 18), 0, 0, 0, 32'h0, 1);

        foreach (tbl[i]) begin
            issue(tbl[i].r, w, mr, mw, ad);
            chk($sformatf("tbl%0d_wait", i), w, tbl[i].waits);
            chk($sformatf("tbl%0d_mr", i), {31'b0, mr},
                {31'b0, tbl[i].mr});
            chk($sformatf("tbl%0d_valid", i), {31'b0, wb_valid},
                {31'b0, tbl[i].v});
            chk($sformatf("tbl%0d_mis", i), {31'b0, misaligned},
                {31'b0, tbl[i].mis});
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_data", i), wb_data, tbl[i].data);
                chk($sformatf("tbl%0d_rd", i), {27'b0, wb_rd},
                    {27'b0, tbl[i].r.rd});
            end
            if (tbl[i].r.ld ^ tbl[i].r.st && tbl[i].r.st &&
                !mdl_mis(tbl[i].r))
                mdl_store(tbl[i].r);
        end
        idle_cycle();
        chk("tbl_mem10", mem[4], 32'h1234_AABB);
        chk("tbl_mem14", mem[5], 32'hDEAD_BEEF);

        // Reset during RMW_WR drops the pending write.
        r = mk(0, 1, 0, 0, 32'h10, 32'h77, 0);
        is_load = r.ld; is_store = r.st; size = r.size;
        ld_unsigned = r.uns; addr = r.addr; store_data = r.sd;
        rd_in = r.rd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rmw_rst_no_write", {31'b0, dm_MemWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rmw_rst_valid", {31'b0, wb_valid}, 32'd0);
        chk("rmw_rst_mis", {31'b0, misaligned}, 32'd0);
        chk("rmw_rst_data", wb_data, 32'd0);
        chk("rmw_rst_rd", {27'b0, wb_rd}, 32'd0);
        chk("rmw_rst_mem", mem[4], 32'h1234_AABB);
        @(negedge clk);

        // Top word of the address space.
        r = mk(1, 0, 2, 0, 32'hFFFF_FFFC, 0, 20);
        issue(r, w, mr, mw, ad);
        chk("top_lw_addr", ad, 32'hFFFF_FFFC);
        chk("top_lw_data", wb_data, mdl_load(r));
        r = mk(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h3C, 0);
        issue(r, w, mr, mw, ad);
        mdl_store(r);
        r = mk(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 21);
        issue(r, w, mr, mw, ad);
        chk("top_lbu_wait", w, 1);
        chk("top_lbu_data", wb_data, 32'h0000_003C);

        // Random traffic against the byte model.
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int   k;
            logic one;
            logic m;
            k = $urandom_range(0, 9);
            r = mk(k <= 5, k == 0 || k >= 6, 2'($urandom_range(0, 3)),
                   1'($urandom), 32'($urandom_range(0, 255)),
                   $urandom, 5'($urandom));
            issue(r, w, mr, mw, ad);
            one = r.ld ^ r.st;
            m = mdl_mis(r);
            chk("rnd_wait", w, pend ? 1 : 0);
            chk("rnd_valid", {31'b0, wb_valid},
                {31'b0, one & r.ld & ~m});
            chk("rnd_mis", {31'b0, misaligned}, {31'b0, one & m});
            chk("rnd_mr", {31'b0, mr},
                {31'b0, one & ~m & (r.ld | (r.size != 2'b10))});
            chk("rnd_mw", {31'b0, mw},
                {31'b0, one & ~m & r.st & (r.size == 2'b10)});
            if (one && r.ld && !m) begin
                chk("rnd_data", wb_data, mdl_load(r));
                chk("rnd_rd", {27'b0, wb_rd}, {27'b0, r.rd});
            end
            pend = one & r.st & ~m & (r.size != 2'b10);
            if (one && r.st && !m) mdl_store(r);
        end
        idle_cycle();
        idle_cycle();

        for (int i = 0; i < 64; i++)
            chk($sformatf("mem_w%0d", i), mem[i], mdl_word(i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
